// File: rtl/dvi_timing_pkg.sv
// Shared 640x480@60 timing constants, capture FSM states and small helpers
// used by both the DVI transmit driver and the DDR capture path.
package dvi_timing_pkg;

   localparam int unsigned H_TOTAL      = 800;
   localparam int unsigned H_ACTIVE     = 640;
   localparam int unsigned H_SYNC_START = 656;
   localparam int unsigned H_SYNC_END   = 752;
   localparam int unsigned V_TOTAL      = 525;
   localparam int unsigned V_ACTIVE     = 480;
   localparam int unsigned V_SYNC_START = 490;
   localparam int unsigned V_SYNC_END   = 492;
   localparam int unsigned LOCK_FRAMES  = 2;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_CHECK  = 2'd1,
      ST_LOCKED = 2'd2
   } dvi_state_e;

   // Rebuild RGB555 from the rising (r) and falling (f) halves of dvi_d[11:4]; f[7] is don't-care.
   function automatic logic [14:0] assemble_pix(input logic [7:0] r, input logic [7:0] f);
      return {r[4:0], f[1:0], r[7:5], f[6:2]};
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : (v + 16'd1);
   endfunction

endpackage

// File: rtl/dvi_ddr_capture_if.sv
// DVI IDF input bus plus the reassembled pixel stream and lock status.
interface dvi_ddr_capture_if;

   logic [11:0] dvi_d;
   logic        dvi_de;
   logic        dvi_h;
   logic        dvi_v;
   logic [14:0] pix_data;
   logic        pix_valid;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic        frame_start;
   logic        locked;
   logic [15:0] err_count;

   modport master (
      output dvi_d, dvi_de, dvi_h, dvi_v,
      input  pix_data, pix_valid, pix_x, pix_y, frame_start, locked, err_count
   );

   modport slave (
      input  dvi_d, dvi_de, dvi_h, dvi_v,
      output pix_data, pix_valid, pix_x, pix_y, frame_start, locked, err_count
   );

endinterface

// File: rtl/dvi_ddr_iddr.sv
// Two-edge sampler for the upper DVI data byte; both halves of a clock are
// re-timed onto the following rising edge so they leave the block aligned.
module dvi_ddr_iddr (
   input  logic       clk25_2_270deg,
   input  logic       reset_n,
   input  logic [7:0] d,
   output logic [7:0] r_byte,
   output logic [7:0] f_byte
);

   logic [7:0] r_q_r;
   logic [7:0] f_q_r;

   // Rising-edge half capture and re-timing of both halves
   always_ff @(posedge clk25_2_270deg or negedge reset_n) begin
      if (!reset_n) begin
         r_q_r  <= 8'h00;
         r_byte <= 8'h00;
         f_byte <= 8'h00;
      end else begin
         r_q_r  <= d;
         r_byte <= r_q_r;
         f_byte <= f_q_r;
      end
   end

   // Falling-edge half capture
   always_ff @(negedge clk25_2_270deg or negedge reset_n) begin
      if (!reset_n) begin
         f_q_r <= 8'h00;
      end else begin
         f_q_r <= d;
      end
   end

endmodule

// File: rtl/dvi_ddr_capture.sv
// DVI DDR receive path: pixel reassembly, coordinate tracking and
// 640x480 timing lock supervision.
module dvi_ddr_capture
   import dvi_timing_pkg::*;
#(
   parameter int unsigned CFG_H_TOTAL     = H_TOTAL,
   parameter int unsigned CFG_H_ACTIVE    = H_ACTIVE,
   parameter int unsigned CFG_V_TOTAL     = V_TOTAL,
   parameter int unsigned CFG_V_ACTIVE    = V_ACTIVE,
   parameter int unsigned CFG_LOCK_FRAMES = LOCK_FRAMES
) (
   input  logic             clk25_2_270deg,
   input  logic             reset_n,
   dvi_ddr_capture_if.slave bus
);

   logic [7:0]  r_byte_s;
   logic [7:0]  f_byte_s;
   logic        de_q_r, hs_q_r, vs_q_r;
   logic        de_a_r, hs_a_r, vs_a_r;
   logic        de_p_r, hs_p_r, vs_p_r;
   logic        de_rise_s, de_fall_s, hs_fall_s, vs_fall_s;
   logic        per_bad_s, wid_bad_s, frame_bad_s;
   logic        first_pend_r;
   logic        line_bad_r;
   logic [15:0] period_r;
   logic [15:0] width_r;
   logic [15:0] hs_cnt_r;
   logic [15:0] de_lines_r;
   logic [15:0] good_cnt_r;
   dvi_state_e  state_r;

   dvi_ddr_iddr u_iddr (
      .clk25_2_270deg (clk25_2_270deg),
      .reset_n        (reset_n),
      .d              (bus.dvi_d[11:4]),
      .r_byte         (r_byte_s),
      .f_byte         (f_byte_s)
   );

   // Control sampling: *_a_r line up with the re-timed data bytes
   always_ff @(posedge clk25_2_270deg or negedge reset_n) begin
      if (!reset_n) begin
         {de_q_r, hs_q_r, vs_q_r} <= 3'b000;
         {de_a_r, hs_a_r, vs_a_r} <= 3'b000;
         {de_p_r, hs_p_r, vs_p_r} <= 3'b000;
      end else begin
         {de_q_r, hs_q_r, vs_q_r} <= {bus.dvi_de, bus.dvi_h, bus.dvi_v};
         {de_a_r, hs_a_r, vs_a_r} <= {de_q_r, hs_q_r, vs_q_r};
         {de_p_r, hs_p_r, vs_p_r} <= {de_a_r, hs_a_r, vs_a_r};
      end
   end

   // Edge events and line/frame judgement on the aligned stage
   always_comb begin
      de_rise_s   = de_a_r & ~de_p_r;
      de_fall_s   = ~de_a_r & de_p_r;
      hs_fall_s   = ~hs_a_r & hs_p_r;
      vs_fall_s   = ~vs_a_r & vs_p_r;
      // the first line of a frame has no predecessor to measure against
      per_bad_s   = de_rise_s & ~vs_fall_s & (de_lines_r != 16'd0) &
                    (period_r != 16'(CFG_H_TOTAL));
      wid_bad_s   = de_fall_s & (width_r != 16'(CFG_H_ACTIVE));
      frame_bad_s = line_bad_r | wid_bad_s |
                    (hs_cnt_r != 16'(CFG_V_TOTAL)) | (de_lines_r != 16'(CFG_V_ACTIVE));
   end

   // Pixel output stage and coordinate counters
   always_ff @(posedge clk25_2_270deg or negedge reset_n) begin
      if (!reset_n) begin
         bus.pix_data    <= 15'd0;
         bus.pix_valid   <= 1'b0;
         bus.pix_x       <= 10'd0;
         bus.pix_y       <= 10'd0;
         bus.frame_start <= 1'b0;
         first_pend_r    <= 1'b0;
      end else begin
         bus.pix_data    <= assemble_pix(r_byte_s, f_byte_s);
         bus.pix_valid   <= de_a_r;
         bus.frame_start <= de_rise_s & (vs_fall_s | first_pend_r);
         if (de_rise_s) begin
            bus.pix_x <= 10'd0;
         end else if (de_a_r && (bus.pix_x != 10'h3FF)) begin
            bus.pix_x <= bus.pix_x + 10'd1;
         end
         // a VSYNC in the same cycle as the DE rise already makes this row 0
         if (de_rise_s) begin
            first_pend_r <= 1'b0;
            if (vs_fall_s || first_pend_r) begin
               bus.pix_y <= 10'd0;
            end else if (bus.pix_y != 10'h3FF) begin
               bus.pix_y <= bus.pix_y + 10'd1;
            end
         end else if (vs_fall_s) begin
            first_pend_r <= 1'b1;
         end
      end
   end

   // Line period/width and per-frame HSYNC/DE-line measurement
   always_ff @(posedge clk25_2_270deg or negedge reset_n) begin
      if (!reset_n) begin
         period_r   <= 16'd0;
         width_r    <= 16'd0;
         hs_cnt_r   <= 16'd0;
         de_lines_r <= 16'd0;
         line_bad_r <= 1'b0;
      end else begin
         period_r <= de_rise_s ? 16'd1 : sat_inc16(period_r);
         if (de_rise_s) begin
            width_r <= 16'd1;
         end else if (de_a_r) begin
            width_r <= sat_inc16(width_r);
         end
         if (vs_fall_s) begin
            hs_cnt_r   <= {15'd0, hs_fall_s};
            de_lines_r <= {15'd0, de_rise_s};
            line_bad_r <= 1'b0;
         end else begin
            hs_cnt_r   <= hs_fall_s ? sat_inc16(hs_cnt_r) : hs_cnt_r;
            de_lines_r <= de_rise_s ? sat_inc16(de_lines_r) : de_lines_r;
            line_bad_r <= line_bad_r | per_bad_s | wid_bad_s;
         end
      end
   end

   // Lock supervision FSM; every VSYNC assertion closes one frame
   always_ff @(posedge clk25_2_270deg or negedge reset_n) begin
      if (!reset_n) begin
         state_r       <= ST_SEARCH;
         good_cnt_r    <= 16'd0;
         bus.locked    <= 1'b0;
         bus.err_count <= 16'd0;
      end else begin
         case (state_r)
            ST_SEARCH: begin
               if (vs_fall_s) begin
                  state_r    <= ST_CHECK;
                  good_cnt_r <= 16'd0;
               end
            end
            ST_CHECK: begin
               if (vs_fall_s) begin
                  if (frame_bad_s) begin
                     good_cnt_r    <= 16'd0;
                     bus.err_count <= sat_inc16(bus.err_count);
                  end else if ((good_cnt_r + 16'd1) >= 16'(CFG_LOCK_FRAMES)) begin
                     good_cnt_r <= 16'd0;
                     state_r    <= ST_LOCKED;
                     bus.locked <= 1'b1;
                  end else begin
                     good_cnt_r <= good_cnt_r + 16'd1;
                  end
               end
            end
            ST_LOCKED: begin
               if (vs_fall_s && frame_bad_s) begin
                  bus.err_count <= sat_inc16(bus.err_count);
                  bus.locked    <= 1'b0;
                  state_r       <= ST_SEARCH;
               end
            end
            default: begin
               state_r    <= ST_SEARCH;
               good_cnt_r <= 16'd0;
               bus.locked <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dvi_ddr_capture.sv
// Directed bench for dvi_ddr_capture on a shrunken raster (20x10 clocks,
// 12x6 active) so many whole frames fit in a short run.
module tb_dvi_ddr_capture;

   localparam int H_T      = 20;
   localparam int H_A      = 12;
   localparam int V_T      = 10;
   localparam int V_A      = 6;
   localparam int HS0      = 14;
   localparam int HS1      = 17;
   localparam int VS0      = 7;
   localparam int VS1      = 8;
   localparam int LONG_LEN = 1040;
   localparam int LONG_DE  = 1030;

   logic clk25_2_270deg = 1'b0;
   logic reset_n;

   dvi_ddr_capture_if bus ();

   dvi_ddr_capture #(
      .CFG_H_TOTAL     (H_T),
      .CFG_H_ACTIVE    (H_A),
      .CFG_V_TOTAL     (V_T),
      .CFG_V_ACTIVE    (V_A),
      .CFG_LOCK_FRAMES (2)
   ) dut (
      .clk25_2_270deg (clk25_2_270deg),
      .reset_n        (reset_n),
      .bus            (bus)
   );

   always #20 clk25_2_270deg = ~clk25_2_270deg;

   typedef struct packed {
      logic        v;
      logic        chk_y;
      logic [14:0] d;
      logic [9:0]  x;
      logic [9:0]  y;
   } exp_t;

   typedef struct {
      logic [11:0] rw;
      logic [11:0] fw;
      logic [14:0] pix;
   } vec_t;

   exp_t pipe0, pipe1;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [11:0] enc_r(input logic [14:0] p, input logic [3:0] n);
      return {p[7], p[6], p[5], p[14], p[13], p[12], p[11], p[10], n};
   endfunction

   function automatic logic [11:0] enc_f(input logic [14:0] p, input logic [3:0] n, input logic dc);
      return {dc, p[4], p[3], p[2], p[1], p[0], p[9], p[8], n};
   endfunction

   task automatic check_pix(input exp_t e);
      chk("pix_valid", {31'd0, bus.pix_valid}, {31'd0, e.v});
      chk("frame_start", {31'd0, bus.frame_start},
          {31'd0, (e.v && e.chk_y && (e.x == 10'd0) && (e.y == 10'd0))});
      if (e.v) begin
         chk("pix_data", {17'd0, bus.pix_data}, {17'd0, e.d});
         chk("pix_x", {22'd0, bus.pix_x}, {22'd0, e.x});
         if (e.chk_y) chk("pix_y", {22'd0, bus.pix_y}, {22'd0, e.y});
      end
   endtask

   // One clock: R word before the rising edge, F word before the falling edge.
   task automatic drive_raw(input logic [11:0] rw, input logic [11:0] fw,
                            input logic de, input logic hs, input logic vs, input exp_t e);
      bus.dvi_d  = rw;
      bus.dvi_de = de;
      bus.dvi_h  = hs;
      bus.dvi_v  = vs;
      @(posedge clk25_2_270deg);
      #10;
      check_pix(pipe1);
      pipe1 = pipe0;
      pipe0 = e;
      bus.dvi_d = fw;
      @(negedge clk25_2_270deg);
      #10;
   endtask

   task automatic gen_frame(input int start_line, input int n_lines, input int short_line,
                            input int long_line, input logic chk_y, input int pat);
      int          len;
      int          w;
      logic        de, hs, vs;
      logic [14:0] p;
      exp_t        e;
      for (int l = start_line; l < n_lines; l++) begin
         len = (l == long_line) ? LONG_LEN : H_T;
         w   = (l == short_line) ? (H_A - 1) : ((l == long_line) ? LONG_DE : H_A);
         for (int h = 0; h < len; h++) begin
            de = (l < V_A) && (h < w);
            hs = !((h >= HS0) && (h < HS1));
            vs = !((l >= VS0) && (l < VS1));
            if (pat == 0) p = (((h + l) % 2) == 1) ? 15'h2AAA : 15'h7FFF;
            else          p = 15'(((h % 32) << 10) | ((l % 32) << 5) | ((h ^ l) % 32));
            e.v     = de;
            e.chk_y = chk_y;
            e.d     = p;
            e.x     = (h > 1023) ? 10'd1023 : 10'(h);
            e.y     = 10'(l);
            drive_raw(enc_r(p, 4'($urandom_range(15))),
                      enc_f(p, 4'($urandom_range(15)), 1'($urandom_range(1))),
                      de, hs, vs, e);
         end
      end
   endtask

   task automatic chk_lock(input string name, input logic lk, input logic [15:0] errs);
      chk({name, "_locked"}, {31'd0, bus.locked}, {31'd0, lk});
      chk({name, "_err_count"}, {16'd0, bus.err_count}, {16'd0, errs});
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_pix_data"}, {17'd0, bus.pix_data}, 32'd0);
      chk({name, "_pix_valid"}, {31'd0, bus.pix_valid}, 32'd0);
      chk({name, "_pix_x"}, {22'd0, bus.pix_x}, 32'd0);
      chk({name, "_pix_y"}, {22'd0, bus.pix_y}, 32'd0);
      chk({name, "_frame_start"}, {31'd0, bus.frame_start}, 32'd0);
      chk({name, "_locked"}, {31'd0, bus.locked}, 32'd0);
      chk({name, "_err_count"}, {16'd0, bus.err_count}, 32'd0);
   endtask

   vec_t vt[18];
   exp_t e;

   initial begin
      // Bit walk: one set pix bit per entry, low nibble noise, F bit 11 don't-care.
      vt[0]  = '{12'h010, 12'h00A, 15'h0400};
      vt[1]  = '{12'h020, 12'h005, 15'h0800};
      vt[2]  = '{12'h040, 12'h00F, 15'h1000};
      vt[3]  = '{12'h080, 12'h003, 15'h2000};
      vt[4]  = '{12'h100, 12'h00C, 15'h4000};
      vt[5]  = '{12'h200, 12'h009, 15'h0020};
      vt[6]  = '{12'h400, 12'h006, 15'h0040};
      vt[7]  = '{12'h800, 12'h001, 15'h0080};
      vt[8]  = '{12'h005, 12'h010, 15'h0100};
      vt[9]  = '{12'h00A, 12'h020, 15'h0200};
      vt[10] = '{12'h003, 12'h040, 15'h0001};
      vt[11] = '{12'h00C, 12'h080, 15'h0002};
      vt[12] = '{12'h00F, 12'h100, 15'h0004};
      vt[13] = '{12'h007, 12'h200, 15'h0008};
      vt[14] = '{12'h00E, 12'h400, 15'h0010};
      vt[15] = '{12'h009, 12'h800, 15'h0000};
      vt[16] = '{12'h00F, 12'h00F, 15'h0000};
      vt[17] = '{12'hFF0, 12'hFFF, 15'h7FFF};

      bus.dvi_d  = 12'h000;
      bus.dvi_de = 1'b0;
      bus.dvi_h  = 1'b1;
      bus.dvi_v  = 1'b1;
      reset_n    = 1'b0;
      pipe0      = '0;
      pipe1      = '0;
      repeat (3) @(negedge clk25_2_270deg);
      #10;
      chk_all_zero("reset");
      reset_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         e.v = 1'b1; e.chk_y = 1'b0; e.d = vt[i].pix; e.x = 10'(i); e.y = 10'd0;
         drive_raw(vt[i].rw, vt[i].fw, 1'b1, 1'b1, 1'b1, e);
      end
      repeat (4) drive_raw(12'h000, 12'h000, 1'b0, 1'b1, 1'b1, '0);

      // Lock acquisition: partial frame, then two judged clean frames.
      gen_frame(4, V_T, -1, -1, 1'b0, 0);
      gen_frame(0, V_T, -1, -1, 1'b1, 0);
      chk_lock("judged1", 1'b0, 16'd0);
      gen_frame(0, V_T, -1, -1, 1'b1, 1);
      chk_lock("judged2", 1'b1, 16'd0);

      // Short DE line while locked, then relock.
      gen_frame(0, V_T, 2, -1, 1'b1, 0);
      chk_lock("short_line", 1'b0, 16'd1);
      gen_frame(0, V_T, -1, -1, 1'b1, 1);
      gen_frame(0, V_T, -1, -1, 1'b1, 0);
      chk_lock("relock_mid", 1'b0, 16'd1);
      gen_frame(0, V_T, -1, -1, 1'b1, 1);
      chk_lock("relock", 1'b1, 16'd1);

      // One line short of V_TOTAL while locked; the next VSYNC sees 9 HSYNCs.
      gen_frame(0, V_T - 1, -1, -1, 1'b1, 0);
      chk_lock("short_frame_pre", 1'b1, 16'd1);
      gen_frame(0, V_T, -1, -1, 1'b1, 1);
      chk_lock("short_frame_locked", 1'b0, 16'd2);

      // Same fault while still in CHECK: counted, lock stays low.
      gen_frame(0, V_T, -1, -1, 1'b1, 0);
      gen_frame(0, V_T - 1, -1, -1, 1'b1, 1);
      gen_frame(0, V_T, -1, -1, 1'b1, 0);
      chk_lock("short_frame_check", 1'b0, 16'd3);
      gen_frame(0, V_T, -1, -1, 1'b1, 1);
      chk_lock("check_good1", 1'b0, 16'd3);
      gen_frame(0, V_T, -1, -1, 1'b1, 0);
      chk_lock("check_lock", 1'b1, 16'd3);

      // Over-long DE line: pix_x saturates at 1023 and the frame is bad.
      gen_frame(0, V_T, -1, 1, 1'b1, 1);
      chk_lock("long_line", 1'b0, 16'd4);
      gen_frame(0, V_T, -1, -1, 1'b1, 0);
      gen_frame(0, V_T, -1, -1, 1'b1, 1);
      gen_frame(0, V_T, -1, -1, 1'b1, 0);
      chk_lock("long_relock", 1'b1, 16'd4);

      // Asynchronous reset in the middle of a DE line while locked.
      gen_frame(0, 3, -1, -1, 1'b1, 1);
      for (int h = 0; h < 5; h++) begin
         e.v = 1'b1; e.chk_y = 1'b1; e.d = 15'h1234 + 15'(h); e.x = 10'(h); e.y = 10'd3;
         drive_raw(enc_r(e.d, 4'h5), enc_f(e.d, 4'hA, 1'b1), 1'b1, 1'b1, 1'b1, e);
      end
      chk("pre_reset_valid", {31'd0, bus.pix_valid}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk_all_zero("mid_reset");
      bus.dvi_de = 1'b0;
      repeat (2) @(negedge clk25_2_270deg);
      #10;
      reset_n = 1'b1;
      pipe0   = '0;
      pipe1   = '0;
      gen_frame(3, V_T, -1, -1, 1'b0, 0);
      gen_frame(0, V_T, -1, -1, 1'b1, 1);
      chk_lock("post_reset1", 1'b0, 16'd0);
      gen_frame(0, V_T, -1, -1, 1'b1, 0);
      chk_lock("post_reset2", 1'b1, 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dvi_ddr_capture.md
# dvi_ddr_capture

Receive-side counterpart of the CH7301C DVI transmit path. Samples the 12-bit DDR IDF bus plus DE/HSYNC/VSYNC, reassembles 15-bit RGB555 pixels, tracks pixel coordinates, and checks 640x480@60 timing. Sits at the board loopback/test input and feeds pixel checkers and frame capture logic.

## Interface
- H_TOTAL, 800, clocks per line
- H_ACTIVE, 640, DE-high clocks per line
- V_TOTAL, 525, HSYNC assertions per frame
- V_ACTIVE, 480, DE lines per frame
- LOCK_FRAMES, 2, consecutive good frames required to assert locked
- clk25_2_270deg  in  1  capture clock, 25.2 MHz, 270° phase
- reset_n  in  1  asynchronous, active-low reset
- dvi_d  in  12  DDR data bus; bits [3:0] ignored
- dvi_de  in  1  data enable, active-high
- dvi_h  in  1  HSYNC, active-low
- dvi_v  in  1  VSYNC, active-low
- pix_data  out  15  reassembled RGB555 pixel
- pix_valid  out  1  pix_data/pix_x/pix_y valid this cycle
- pix_x  out  10  column of pix_data, 0..639
- pix_y  out  10  row of pix_data, 0..479
- frame_start  out  1  one-cycle pulse with first valid pixel of a frame
- locked  out  1  timing matched for LOCK_FRAMES consecutive frames
- err_count  out  16  count of bad frames, saturates at 0xFFFF

## Operation
- Rising-edge half (R) and falling-edge half (F) of each clock form one pixel.
- Bit map, dvi_d[4..11]: R = pix[10],pix[11],pix[12],pix[13],pix[14],pix[5],pix[6],pix[7]; F = pix[8],pix[9],pix[0],pix[1],pix[2],pix[3],pix[4],don't-care.
- dvi_de, dvi_h, dvi_v sampled on rising edge only, delayed to align with pix_data.
- pix_x: 0 on first DE-high cycle of a line, +1 per valid pixel, saturates at 1023.
- pix_y: 0 on first DE line after VSYNC assertion (falling edge of dvi_v), +1 per subsequent DE rising edge, saturates at 1023.
- Per-line check: DE-rise-to-DE-rise period != H_TOTAL or DE width != H_ACTIVE marks current frame bad.
- Per-frame check at each VSYNC assertion: HSYNC assertions != V_TOTAL or DE lines != V_ACTIVE marks frame bad.
- FSM states:
  - SEARCH: wait for VSYNC assertion -> CHECK; good_cnt=0.
  - CHECK: at VSYNC assertion, good frame -> good_cnt+1, reaching LOCK_FRAMES -> LOCKED; bad frame -> good_cnt=0, err_count+1, stay CHECK.
  - LOCKED: bad frame -> err_count+1, locked drops, -> SEARCH; good frame -> stay.
- Truncated first frame after reset or SEARCH entry is never judged.
- VSYNC assertion and DE rise in same cycle: frame boundary processed first; that line is row 0 of new frame.
- Line >1023 DE clocks: pix_x holds 1023, line bad.

## Timing
- Input IOB stage: R sampled at rising edge n, F at falling edge n+½, both presented at rising edge n+1 (same-edge-pipelined).
- pix_data/pix_valid/pix_x/pix_y registered at edge n+2: latency 2 cycles from DE-high sample.
- frame_start coincident with pix_valid for pixel (0,0).
- locked/err_count update the cycle after the VSYNC-assertion sample.
- Reset (any time, async): pix_data=0, pix_valid=0, pix_x=0, pix_y=0, frame_start=0, locked=0, err_count=0, FSM=SEARCH, all measurement counters 0, IOB registers 0.

## Structure
- dvi_timing_pkg: H_TOTAL/H_ACTIVE/H_SYNC_START(656)/H_SYNC_END(752)/V_TOTAL/V_ACTIVE/V_SYNC_START(490)/V_SYNC_END(492) constants, FSM state enum; shared with the transmit driver.
- Sub-module dvi_ddr_iddr: per-bit two-edge sampler (IDDR wrapper) for dvi_d[11:4], produces aligned R/F bytes.

## Test plan
- Loopback from transmit driver, pix_data = 15'h7FFF then 15'h2AAA checkerboard -> identical values out 2 cycles after DE, pix_x 0..639, pix_y 0..479.
- Three clean frames after reset -> locked rises at 2nd judged frame's VSYNC, err_count=0.
- Locked, one line with DE 639 clocks -> at next VSYNC locked=0, err_count=1, FSM SEARCH; relock after 2 further good frames.
- Frame with 524 lines -> bad frame, err_count increments, locked stays 0.
- Reset asserted mid-line while locked -> all outputs 0 immediately; post-release first partial frame not counted.
- Bit walk: single 1 through each pix bit -> appears on correct pix_data bit only; dvi_d[3:0] toggling has no effect.
